dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 148 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin with bounded read-modify-write locking.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed port-0 priority (locks apply to port 0 only).
`timescale 1ns/1ps
module dmem_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic [AW-1:0] adr0,
    input  logic [AW-1:0] adr1,
    input  logic [DW-1:0] wd0,
    input  logic [DW-1:0] wd1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rd0,
    output logic [DW-1:0] rd1,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_t;

    localparam logic [3:0] LOCK_LIM = 4'(LOCK_MAX);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rvalid0_q, rvalid0_d;
    logic       rvalid1_q, rvalid1_d;

    logic       lk0, lk1;
    logic       held0, held1;
    logic       g0, g1;

    // A lock only counts when its port is also requesting.
    assign lk0 = lock0 & req0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign lk1 = 1'b0;
`else
    assign lk1 = lock1 & req1;
`endif

    assign held0 = (state_q == OWN0) && lk0 && (cnt_q < LOCK_LIM);
    assign held1 = (state_q == OWN1) && lk1 && (cnt_q < LOCK_LIM);

    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (reset) begin
            if (req0 && !req1) begin
                g0 = 1'b1;
            end else if (req1 && !req0) begin
                g1 = 1'b1;
            end else if (req0 && req1) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                // Port 0 wins unless its lock has run out of budget.
                if ((state_q == OWN0) && lk0 && (cnt_q >= LOCK_LIM)) begin
                    g1 = 1'b1;
                end else begin
                    g0 = 1'b1;
                end
`else
                if (held0) begin
                    g0 = 1'b1;
                end else if (held1) begin
                    g1 = 1'b1;
                end else if (state_q == OWN0) begin
                    g1 = 1'b1;
                end else begin
                    g0 = 1'b1;
                end
`endif
            end
        end
    end

    always_comb begin
        state_d   = IDLE;
        cnt_d     = '0;
        rvalid0_d = g0 & ~we0;
        rvalid1_d = g1 & ~we1;
        if (g0) begin
            state_d = OWN0;
            if ((state_q == OWN0) && lk0) begin
                cnt_d = (cnt_q >= LOCK_LIM) ? LOCK_LIM : cnt_q + 4'd1;
            end
        end else if (g1) begin
            state_d = OWN1;
            if ((state_q == OWN1) && lk1) begin
                cnt_d = (cnt_q >= LOCK_LIM) ? LOCK_LIM : cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    assign gnt0 = g0;
    assign gnt1 = g1;

    always_comb begin
        mem_we  = 1'b0;
        mem_adr = '0;
        mem_wd  = '0;
        if (g0) begin
            mem_we  = we0;
            mem_adr = adr0;
            mem_wd  = wd0;
        end else if (g1) begin
            mem_we  = we1;
            mem_adr = adr1;
            mem_wd  = wd1;
        end
    end

    // Gating with reset drops a read that is in flight when reset arrives.
    assign rvalid0 = rvalid0_q & reset;
    assign rvalid1 = rvalid1_q & reset;
    assign rd0     = rvalid0 ? mem_rd : '0;
    assign rd1     = rvalid1 ? mem_rd : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus queues expected grants/bus/read data,
// a negedge monitor pops and compares. Honours DMEM_ARB_FIXED_PRIO_EN.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct packed {
        logic          r;
        logic          w;
        logic          l;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } port_t;

    typedef struct packed {
        logic          g0;
        logic          g1;
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] wd;
    } bus_t;

    typedef struct packed {
        int unsigned   due;
        logic [DW-1:0] data;
    } rd_t;

    logic          clk;
    logic          reset;
    logic          req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0] adr0, adr1;
    logic [DW-1:0] wd0, wd1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rd0, rd1;
    logic          mem_we;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    dmem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .adr0(adr0), .adr1(adr1), .wd0(wd0), .wd1(wd1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rd0(rd0), .rd1(rd1),
        .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int i);
        init_val = (i == 'h60) ? 32'h19 : (32'hC0DE_0000 | 32'(i));
    endfunction

    // Synchronous-read memory model (one cycle latency).
    logic [DW-1:0] mem [256];
    logic          preload;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else if (mem_we) begin
            mem[mem_adr[7:0]] <= mem_wd;
        end
        mem_rd <= mem[mem_adr[7:0]];
    end

    logic [DW-1:0] shadow [256];
    bus_t          gq[$];
    rd_t           rq0[$];
    rd_t           rq1[$];
    int            errors = 0;
    int            checks = 0;
    int unsigned   cyc_n = 0;
    bit            mon_en = 1'b0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic port_t NONE();
        NONE = '0;
    endfunction
    function automatic port_t RD(input logic [AW-1:0] a);
        RD = '0; RD.r = 1'b1; RD.a = a;
    endfunction
    function automatic port_t LRD(input logic [AW-1:0] a);
        LRD = RD(a); LRD.l = 1'b1;
    endfunction
    function automatic port_t WR(input logic [AW-1:0] a, input logic [DW-1:0] d);
        WR = '0; WR.r = 1'b1; WR.w = 1'b1; WR.a = a; WR.d = d;
    endfunction
    function automatic port_t LWR(input logic [AW-1:0] a, input logic [DW-1:0] d);
        LWR = WR(a, d); LWR.l = 1'b1;
    endfunction

    task automatic step(input logic rst, input port_t p0, input port_t p1,
                        input logic e0, input logic e1);
        bus_t b;
        rd_t  r;
        @(posedge clk);
        #1;
        reset = rst;
        req0 = p0.r; we0 = p0.w; lock0 = p0.l; adr0 = p0.a; wd0 = p0.d;
        req1 = p1.r; we1 = p1.w; lock1 = p1.l; adr1 = p1.a; wd1 = p1.d;
        if (!rst) begin
            rq0.delete();
            rq1.delete();
        end
        b = '0;
        b.g0 = e0;
        b.g1 = e1;
        if (e0) begin
            b.we = p0.w; b.adr = p0.a; b.wd = p0.d;
        end else if (e1) begin
            b.we = p1.w; b.adr = p1.a; b.wd = p1.d;
        end
        gq.push_back(b);
        if (e0 && !p0.w) begin
            r.due = cyc_n + 1; r.data = shadow[p0.a[7:0]]; rq0.push_back(r);
        end
        if (e1 && !p1.w) begin
            r.due = cyc_n + 1; r.data = shadow[p1.a[7:0]]; rq1.push_back(r);
        end
        if (e0 && p0.w) shadow[p0.a[7:0]] = p0.d;
        if (e1 && p1.w) shadow[p1.a[7:0]] = p1.d;
        mon_en = 1'b1;
    endtask

    bus_t mb;
    rd_t  mr;
    always @(negedge clk) begin
        if (mon_en) begin
            if (gq.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_underflow cycle=%0d", cyc_n);
            end else begin
                mb = gq.pop_front();
                checks++;
                if ({gnt0, gnt1} !== {mb.g0, mb.g1}) begin
                    errors++;
                    $display("FAIL grant cycle=%0d got=%b%b exp=%b%b", cyc_n, gnt0, gnt1, mb.g0, mb.g1);
                end
                checks++;
                if ({mem_we, mem_adr, mem_wd} !== {mb.we, mb.adr, mb.wd}) begin
                    errors++;
                    $display("FAIL mem_bus cycle=%0d got we=%b adr=%h wd=%h exp we=%b adr=%h wd=%h",
                             cyc_n, mem_we, mem_adr, mem_wd, mb.we, mb.adr, mb.wd);
                end
            end
            checks++;
            if (rq0.size() != 0 && rq0[0].due == cyc_n) begin
                mr = rq0.pop_front();
                if (rvalid0 !== 1'b1 || rd0 !== mr.data) begin
                    errors++;
                    $display("FAIL rd0 cycle=%0d got v=%b d=%h exp v=1 d=%h", cyc_n, rvalid0, rd0, mr.data);
                end
            end else if (rvalid0 !== 1'b0 || rd0 !== '0) begin
                errors++;
                $display("FAIL rd0_idle cycle=%0d got v=%b d=%h exp v=0 d=0", cyc_n, rvalid0, rd0);
            end
            checks++;
            if (rq1.size() != 0 && rq1[0].due == cyc_n) begin
                mr = rq1.pop_front();
                if (rvalid1 !== 1'b1 || rd1 !== mr.data) begin
                    errors++;
                    $display("FAIL rd1 cycle=%0d got v=%b d=%h exp v=1 d=%h", cyc_n, rvalid1, rd1, mr.data);
                end
            end else if (rvalid1 !== 1'b0 || rd1 !== '0) begin
                errors++;
                $display("FAIL rd1_idle cycle=%0d got v=%b d=%h exp v=0 d=0", cyc_n, rvalid1, rd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle=%0d", cyc_n);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; preload = 1'b1;
        req0 = 1'b0; we0 = 1'b0; lock0 = 1'b0; adr0 = '0; wd0 = '0;
        req1 = 1'b0; we1 = 1'b0; lock1 = 1'b0; adr1 = '0; wd1 = '0;
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        @(posedge clk);
        #1;
        preload = 1'b0;

        // Reset holds grants and mem_we low even with both ports requesting.
        step(1'b0, RD(32'h60), WR(32'h20, 32'h5), 1'b0, 1'b0);
        step(1'b0, RD(32'h60), WR(32'h20, 32'h5), 1'b0, 1'b0);

        // Single read: grant same cycle, data next cycle.
        step(1'b1, RD(32'h60), NONE(), 1'b1, 1'b0);
        step(1'b1, NONE(), NONE(), 1'b0, 1'b0);

        // Contention without lock: alternate (fixed priority: port 0 throughout).
        for (int k = 0; k < 4; k++)
            step(1'b1, RD(32'h10), RD(32'h20), FIXED ? 1'b1 : (k % 2 == 0), FIXED ? 1'b0 : (k % 2 == 1));
        step(1'b1, NONE(), NONE(), 1'b0, 1'b0);

        // Port 1 write alone, then read it back through port 0.
        step(1'b1, NONE(), WR(32'h64, 32'd25), 1'b0, 1'b1);
        step(1'b1, RD(32'h64), NONE(), 1'b1, 1'b0);
        step(1'b1, NONE(), NONE(), 1'b0, 1'b0);

        // Locked port 0 against port 1: 0,0,0,0,0,1,0,0.
        for (int k = 0; k < 8; k++)
            step(1'b1, LRD(32'h30), RD(32'h34), (k != 5), (k == 5));
        step(1'b1, NONE(), NONE(), 1'b0, 1'b0);

        // Lock counter saturates alone, then forced release, then port 1 lock.
        for (int k = 0; k < 6; k++)
            step(1'b1, LWR(32'h40, 32'h100 + 32'(k)), NONE(), 1'b1, 1'b0);
        step(1'b1, LWR(32'h44, 32'h200), LWR(32'h48, 32'h201), 1'b0, 1'b1);
        step(1'b1, LWR(32'h4C, 32'h202), LWR(32'h50, 32'h203), FIXED, !FIXED);
        step(1'b1, RD(32'h40), NONE(), 1'b1, 1'b0);
        step(1'b1, NONE(), RD(32'h48), 1'b0, 1'b1);
        step(1'b1, NONE(), NONE(), 1'b0, 1'b0);

        // Reset right after a granted read: read dropped, state back to IDLE.
        step(1'b1, RD(32'h60), NONE(), 1'b1, 1'b0);
        step(1'b0, RD(32'h10), RD(32'h20), 1'b0, 1'b0);
        step(1'b1, RD(32'h10), RD(32'h20), 1'b1, 1'b0);
        step(1'b1, NONE(), NONE(), 1'b0, 1'b0);
        step(1'b1, NONE(), NONE(), 1'b0, 1'b0);

        #6;
        mon_en = 1'b0;
        checks++;
        if (gq.size() != 0 || rq0.size() != 0 || rq1.size() != 0) begin
            errors++;
            $display("FAIL drain got gq=%0d rq0=%0d rq1=%0d exp all 0", gq.size(), rq0.size(), rq1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
